// File: rtl/pe_feeder_pkg.sv
// Shared types and constants for the PE feeder: FSM states, ctl bit positions, beat width.
package pe_feeder_pkg;

    localparam int BEAT_W    = 512;
    localparam int CTL_FIRST = 0;
    localparam int CTL_LAST  = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/pe_feeder_addr_gen.sv
// Beat/output counters and neuron/weight buffer address generation for one job.
module pe_feeder_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic [LEN_W-1:0]  len,
    input  logic [LEN_W-1:0]  num,
    output logic [ADDR_W-1:0] n_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              first_beat,
    output logic              last_beat,
    output logic              last_out
);

    logic [LEN_W-1:0]  beat;
    logic [LEN_W-1:0]  out;
    // Running out*(len+1), so the weight address needs only one adder.
    logic [ADDR_W-1:0] w_base;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            beat   <= '0;
            out    <= '0;
            w_base <= '0;
        end else if (step) begin
            if (last_beat) begin
                beat   <= '0;
                out    <= out + 1'b1;
                w_base <= w_base + ADDR_W'(len) + ADDR_W'(1);
            end else begin
                beat <= beat + 1'b1;
            end
        end
    end

    assign first_beat = (beat == '0);
    assign last_beat  = (beat == len);
    assign last_out   = (out == num);
    assign n_addr     = ADDR_W'(beat);
    assign w_addr     = w_base + ADDR_W'(beat);

endmodule

// File: rtl/pe_feeder.sv
// Streams neuron/weight beats from two SRAMs into a PE and collects its dot-product results.
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [LEN_W-1:0]  cfg_num,
    input  logic              pause,
    output logic              n_rd_en,
    output logic [ADDR_W-1:0] n_rd_addr,
    input  logic [BEAT_W-1:0] n_rd_data,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    input  logic [BEAT_W-1:0] w_rd_data,
    output logic [BEAT_W-1:0] neuron,
    output logic [BEAT_W-1:0] weight,
    output logic [1:0]        ctl,
    output logic              vld_i,
    input  logic [31:0]       pe_result,
    input  logic              pe_vld,
    output logic [31:0]       res_data,
    output logic              res_vld,
    output logic [LEN_W-1:0]  res_idx,
    output logic              busy,
    output logic              done
);

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  len_q, num_q;
    logic [LEN_W:0]    ret_cnt, ret_nxt, ret_goal;
    logic              issue, clear;
    logic              first_beat, last_beat, last_out;
    logic [ADDR_W-1:0] n_addr, w_addr;
    logic              vld_q;
    logic [1:0]        ctl_q;

    assign issue = (state == S_ISSUE) && !pause;
    assign clear = (state == S_IDLE) && start;

    pe_feeder_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .step       (issue),
        .len        (len_q),
        .num        (num_q),
        .n_addr     (n_addr),
        .w_addr     (w_addr),
        .first_beat (first_beat),
        .last_beat  (last_beat),
        .last_out   (last_out)
    );

    // One extra bit so num+1 results can be counted when num is all ones.
    assign ret_nxt  = ret_cnt + {{LEN_W{1'b0}}, pe_vld};
    assign ret_goal = {1'b0, num_q} + {{LEN_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            len_q   <= '0;
            num_q   <= '0;
            ret_cnt <= '0;
            vld_q   <= 1'b0;
            ctl_q   <= 2'b00;
        end else begin
            state <= state_nxt;
            if (clear) begin
                len_q <= cfg_len;
                num_q <= cfg_num;
            end
            ret_cnt          <= clear ? '0 : ret_nxt;
            vld_q            <= issue;
            ctl_q[CTL_FIRST] <= issue && first_beat;
            ctl_q[CTL_LAST]  <= issue && last_beat;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: if (issue && last_beat && last_out) state_nxt = S_DRAIN;
            S_DRAIN: if (ret_nxt >= ret_goal) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign n_rd_en   = issue;
    assign w_rd_en   = issue;
    assign n_rd_addr = issue ? n_addr : '0;
    assign w_rd_addr = issue ? w_addr : '0;

    // Read data lands one cycle after the enable; vld_q tracks that return.
    assign vld_i  = vld_q;
    assign neuron = vld_q ? n_rd_data : '0;
    assign weight = vld_q ? w_rd_data : '0;
    assign ctl    = ctl_q;

    assign res_vld  = pe_vld;
    assign res_data = pe_vld ? pe_result : '0;
    assign res_idx  = pe_vld ? ret_cnt[LEN_W-1:0] : '0;

    assign busy = (state == S_ISSUE) || (state == S_DRAIN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: SRAM and PE models, table-driven and random jobs.
module tb_pe_feeder;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst, start, pause;
    logic [LEN_W-1:0]  cfg_len, cfg_num;
    logic              n_rd_en, w_rd_en;
    logic [ADDR_W-1:0] n_rd_addr, w_rd_addr;
    logic [511:0]      n_rd_data, w_rd_data, neuron, weight;
    logic [1:0]        ctl;
    logic              vld_i;
    logic [31:0]       pe_result, res_data;
    logic              pe_vld, res_vld;
    logic [LEN_W-1:0]  res_idx;
    logic              busy, done;

    pe_feeder #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_num(cfg_num),
        .pause(pause), .n_rd_en(n_rd_en), .n_rd_addr(n_rd_addr), .n_rd_data(n_rd_data),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .neuron(neuron), .weight(weight), .ctl(ctl), .vld_i(vld_i),
        .pe_result(pe_result), .pe_vld(pe_vld), .res_data(res_data), .res_vld(res_vld),
        .res_idx(res_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    int          mode = 0;
    logic [15:0] seed = 16'h0;

    function automatic logic [511:0] mem_beat(input bit is_w, input int addr);
        logic [511:0] b;
        for (int l = 0; l < 32; l++)
            b[l*16 +: 16] = (mode == 1) ? 16'h0001 :
                            16'(addr * 40503 + l * 2654 + int'(seed) + (is_w ? 12345 : 0));
        return b;
    endfunction

    function automatic logic [511:0] rnd_beat();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [31:0] dot(input logic [511:0] a, input logic [511:0] b);
        logic [31:0] s = 32'd0;
        for (int l = 0; l < 32; l++)
            s = s + 32'(int'($signed(a[l*16 +: 16])) * int'($signed(b[l*16 +: 16])));
        return s;
    endfunction

    // SRAMs: one-cycle read latency, junk on the bus when not reading.
    always @(posedge clk) begin
        n_rd_data <= n_rd_en ? mem_beat(1'b0, int'(n_rd_addr)) : rnd_beat();
        w_rd_data <= w_rd_en ? mem_beat(1'b1, int'(w_rd_addr)) : rnd_beat();
    end

    // PE: accumulates dot products, emits the sum the cycle after a last beat.
    logic [31:0] psum, pe_acc;
    assign pe_acc = (ctl[0] ? 32'd0 : psum) + dot(neuron, weight);
    always @(posedge clk) begin
        if (rst) begin
            pe_vld <= 1'b0; pe_result <= 32'd0; psum <= 32'd0;
        end else begin
            pe_vld <= 1'b0;
            if (vld_i) begin
                psum <= pe_acc;
                if (ctl[1]) begin pe_vld <= 1'b1; pe_result <= pe_acc; end
            end
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int           iss_n[$], iss_w[$], rs_idx[$];
    logic [1:0]   dl_ctl[$];
    logic [511:0] dl_n[$], dl_w[$];
    logic [31:0]  rs_dat[$];
    logic         prev_en;
    int           n_done;

    task automatic sample(input int cyc, input int exp_done);
        chk("rd_en_pair", w_rd_en, n_rd_en);
        chk("vld_follows_rd", vld_i, prev_en);
        if (!vld_i) chk("idle_zero", neuron | weight | {510'd0, ctl}, 512'd0);
        chk("busy", busy, (cyc >= 1 && cyc < exp_done));
        chk("done", done, (cyc == exp_done));
        if (done) n_done++;
        if (n_rd_en) begin iss_n.push_back(int'(n_rd_addr)); iss_w.push_back(int'(w_rd_addr)); end
        if (vld_i) begin dl_ctl.push_back(ctl); dl_n.push_back(neuron); dl_w.push_back(weight); end
        if (res_vld) begin rs_idx.push_back(int'(res_idx)); rs_dat.push_back(res_data); end
        prev_en = n_rd_en;
    endtask

    task automatic check_job(input int len, input int num);
        int          L, N, k;
        logic [31:0] acc;
        L = len + 1;
        N = num + 1;
        chk("issue_count", iss_n.size(), N * L);
        chk("vld_count", dl_ctl.size(), N * L);
        chk("res_count", rs_idx.size(), N);
        chk("done_once", n_done, 1);
        for (int o = 0; o < N; o++) begin
            acc = 32'd0;
            for (int b = 0; b < L; b++) begin
                k = o * L + b;
                acc = acc + dot(mem_beat(1'b0, b), mem_beat(1'b1, k % 1024));
                if (k < iss_n.size()) begin
                    chk("n_rd_addr", iss_n[k], b);
                    chk("w_rd_addr", iss_w[k], k % 1024);
                end
                if (k < dl_ctl.size()) begin
                    chk("ctl", dl_ctl[k], {b == len, b == 0});
                    chk("neuron", dl_n[k], mem_beat(1'b0, b));
                    chk("weight", dl_w[k], mem_beat(1'b1, k % 1024));
                end
            end
            if (o < rs_idx.size()) begin
                chk("res_idx", rs_idx[o], o);
                chk("res_data", rs_dat[o], acc);
                if (mode == 1) chk("res_ones", rs_dat[o], 32'(64 * L / 2));
            end
        end
    endtask

    task automatic run_job(input int len, input int num, input int pstart, input int plen,
                           input int exp_done, input bit drain_start);
        int nl;
        nl = (len + 1) * (num + 1);
        iss_n.delete(); iss_w.delete(); dl_ctl.delete(); dl_n.delete(); dl_w.delete();
        rs_idx.delete(); rs_dat.delete();
        prev_en = 1'b0;
        n_done  = 0;
        @(posedge clk); #1;
        cfg_len = LEN_W'(len); cfg_num = LEN_W'(num); start = 1'b1;
        for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
            @(posedge clk); #1;
            start = drain_start && (cyc == nl + 1);
            if (start) begin cfg_len = 8'd7; cfg_num = 8'd5; end
            pause = (cyc > pstart && cyc <= pstart + plen);
            @(negedge clk);
            sample(cyc, exp_done);
        end
        start = 1'b0;
        pause = 1'b0;
        check_job(len, num);
    endtask

    typedef struct {
        int len; int num; int pstart; int plen; int mode; int exp_done; bit drain_start;
    } vec_t;
    vec_t tbl[6];

    initial begin
        tbl[0] = '{3, 1, 0, 0, 0, 11, 1'b0};  // 8 beats, two dot products
        tbl[1] = '{0, 2, 0, 0, 0,  6, 1'b0};  // single-beat dot products
        tbl[2] = '{3, 1, 2, 2, 0, 13, 1'b0};  // 2-cycle pause mid dot product
        tbl[3] = '{2, 1, 0, 0, 0,  9, 1'b1};  // start + cfg change during DRAIN
        tbl[4] = '{1, 1, 0, 0, 1,  7, 1'b0};  // all-ones vectors, result 64
        tbl[5] = '{2, 3, 5, 1, 0, 16, 1'b0};

        rst = 1'b1; start = 1'b0; pause = 1'b0; cfg_len = '0; cfg_num = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ctl", {n_rd_en, w_rd_en, n_rd_addr, w_rd_addr, vld_i, ctl, res_vld,
                          res_data, res_idx, busy, done}, 512'd0);
        chk("reset_data", neuron | weight, 512'd0);

        foreach (tbl[i]) begin
            mode = tbl[i].mode;
            seed = 16'($urandom);
            run_job(tbl[i].len, tbl[i].num, tbl[i].pstart, tbl[i].plen,
                    tbl[i].exp_done, tbl[i].drain_start);
        end
        mode = 0;

        // Abort mid-job on beat 2, then rerun from address 0.
        @(posedge clk); #1;
        cfg_len = 8'd3; cfg_num = 8'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_beat2_addr", n_rd_addr, 10'd2);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ctl", {n_rd_en, w_rd_en, n_rd_addr, w_rd_addr, vld_i, ctl, res_vld,
                          res_data, res_idx, busy, done}, 512'd0);
        chk("abort_data", neuron | weight, 512'd0);
        run_job(3, 1, 0, 0, 11, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int len, num, plen, pstart;
            len    = $urandom_range(0, 5);
            num    = $urandom_range(0, 4);
            plen   = $urandom_range(0, 3);
            pstart = $urandom_range(0, (len + 1) * (num + 1) - 1);
            seed   = 16'($urandom);
            run_job(len, num, pstart, plen, (len + 1) * (num + 1) + 3 + plen, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter ADDR_W, default 10, SRAM address width for the neuron and weight buffers.
REQ-002 Parameter LEN_W, default 8, width of the beat-count and result-count configuration fields.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle job start pulse; honoured only in IDLE.
REQ-006 cfg_len  input  LEN_W  beats per dot product minus 1 (0 means 1 beat); sampled on an accepted start.
REQ-007 cfg_num  input  LEN_W  results per job minus 1; sampled on an accepted start.
REQ-008 pause  input  1  when high, no new buffer read is issued.
REQ-009 n_rd_en / n_rd_addr  output  1 / ADDR_W  neuron buffer read; data returns 1 cycle later.
REQ-010 n_rd_data  input  512  neuron beat, 32 x int16.
REQ-011 w_rd_en / w_rd_addr  output  1 / ADDR_W  weight buffer read; data returns 1 cycle later.
REQ-012 w_rd_data  input  512  weight beat, 32 x int16.
REQ-013 neuron / weight  output  512 / 512  beat driven to the PE.
REQ-014 ctl  output  2  PE control; bit0 = first beat (psum restarts), bit1 = last beat (result follows).
REQ-015 vld_i  output  1  neuron/weight/ctl valid to the PE.
REQ-016 pe_result / pe_vld  input  32 / 1  PE result and its valid.
REQ-017 res_data / res_vld / res_idx  output  32 / 1 / LEN_W  collected result, its valid, and its output index.
REQ-018 busy / done  output  1 / 1  job active; one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-020 IDLE: on start the FSM SHALL latch cfg_len and cfg_num, clear the beat, output and return counters, and move to ISSUE.
REQ-021 ISSUE with pause low: the block SHALL assert n_rd_en and w_rd_en together, with n_rd_addr = beat and w_rd_addr = out*(len+1) + beat, truncated to ADDR_W.
REQ-022 The beat counter SHALL wrap to 0 after value len, and out SHALL increment at that wrap.
REQ-023 ISSUE SHALL move to DRAIN after issuing beat = len of out = num.
REQ-024 ISSUE with pause high SHALL issue no read and leave the counters unchanged; a read issued in the previous cycle SHALL still be delivered.
REQ-025 vld_i SHALL assert exactly one cycle after each read enable.
REQ-026 neuron and weight SHALL equal the buffer read data in that cycle.
REQ-027 ctl SHALL be delayed 1 cycle to align with the data: bit0 = (beat == 0), bit1 = (beat == len); when len = 0, ctl = 2'b11.
REQ-028 When vld_i is low, neuron, weight and ctl SHALL be zero.
REQ-029 Each cycle with pe_vld high SHALL produce res_vld high the same cycle, with res_data = pe_result and res_idx = the return count; the return count then SHALL increment.
REQ-030 pe_vld SHALL be accepted in any state.
REQ-031 DRAIN SHALL move to DONE when the return count reaches num+1, including when that count is reached in the same cycle pe_vld arrives.
REQ-032 DONE SHALL pulse done for one cycle and then return to IDLE.
REQ-033 busy SHALL be high in ISSUE and DRAIN.
REQ-034 A start pulse outside IDLE SHALL be ignored.
REQ-035 Throughput SHALL be one beat per cycle when pause is low.
REQ-036 For a len+1 = L, num+1 = N job with no pause, done SHALL pulse at cycle N*L + 3 after start.

Reset
REQ-037 rst SHALL return the FSM to IDLE and zero every counter and every output, including vld_i, ctl, res_vld, done and busy.
REQ-038 rst asserted mid-job SHALL abort the job; in-flight reads are discarded and vld_i is low on the next cycle.

Structure
REQ-039 A shared package SHALL hold the FSM state enum, the CTL_FIRST and CTL_LAST bit positions, and the 512-bit beat width constant.
REQ-040 One sub-module, pe_feeder_addr_gen, SHALL contain the beat/out counters and the address computation; the FSM, the data alignment and the result collection stay at top level.

Verification
REQ-041 len=3, num=1, pause low: vld_i on 8 consecutive cycles; ctl = 01,00,00,10,01,00,00,10; w_rd_addr = 0..7; n_rd_addr = 0,1,2,3,0,1,2,3.
REQ-042 len=0, num=2: every beat has ctl=11; the PE model returns 3 results; res_idx = 0,1,2; done pulses once.
REQ-043 pause held high for 2 cycles in the middle of a dot product: a 2-cycle gap in vld_i, no duplicated or skipped address, and the ctl sequence unchanged.
REQ-044 start asserted during DRAIN: ignored, busy stays high, and cfg changes have no effect on the running job.
REQ-045 rst asserted in ISSUE on beat 2: the next cycle shows all outputs 0 and IDLE; a new start then runs correctly from address 0.
REQ-046 Integration with the PE, all-ones int16 vectors, len=1: res_data = 64 on each result.
